// File: rtl/mul3_rem_serial.sv
// Digit-serial D = 3*Q + R reconstruction, LSB digit first, one DIGIT per cycle.
// Define MUL3R_OVF_EN to report a nonzero final carry on ovf; otherwise ovf is 0.
module mul3_rem_serial #(
   parameter int W     = 64,
   parameter int DIGIT = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] q,
   input  logic [1:0]   r,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] d,
   output logic         ovf
);

   localparam int NDIG = W / DIGIT;
   localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [W-1:0]     sh_q, sh_d;
   logic [W-1:0]     acc_q, acc_d;
   logic [1:0]       carry_q, carry_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [DIGIT-1:0] n;
   logic [DIGIT+1:0] t;

   // 3n formed as n + 2n so the sum never exceeds DIGIT+2 bits
   assign n = sh_q[DIGIT-1:0];
   assign t = {2'b00, n} + {1'b0, n, 1'b0} + {{DIGIT{1'b0}}, carry_q};

`ifdef MUL3R_OVF_EN
   logic ovf_q, ovf_d;
`endif

   always_comb begin
      state_d = state_q;
      sh_d    = sh_q;
      acc_d   = acc_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
`ifdef MUL3R_OVF_EN
      ovf_d   = ovf_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               sh_d    = q;
               carry_d = r;
               cnt_d   = '0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            acc_d   = {t[DIGIT-1:0], acc_q[W-1:DIGIT]};
            carry_d = t[DIGIT+1:DIGIT];
            sh_d    = sh_q >> DIGIT;
            if (cnt_q == LAST) begin
               state_d = S_DONE;
`ifdef MUL3R_OVF_EN
               ovf_d   = (t[DIGIT+1:DIGIT] != 2'b00);
`endif
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_DONE: begin
            if (out_ready) begin
               state_d = S_IDLE;
               cnt_d   = '0;
`ifdef MUL3R_OVF_EN
               ovf_d   = 1'b0;
`endif
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         sh_q    <= '0;
         acc_q   <= '0;
         carry_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         sh_q    <= sh_d;
         acc_q   <= acc_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
      end
   end

`ifdef MUL3R_OVF_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) ovf_q <= 1'b0;
      else     ovf_q <= ovf_d;
   end
   assign ovf = ovf_q;
`else
   assign ovf = 1'b0;
`endif

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign d         = acc_q;

endmodule

// File: tb/tb_mul3_rem_serial.sv
// Directed self-checking bench for mul3_rem_serial (default W=64, DIGIT=4).
module tb_mul3_rem_serial;

   localparam int W = 64;

`ifdef MUL3R_OVF_EN
   localparam logic EXP_OVF_WRAP = 1'b1;
`else
   localparam logic EXP_OVF_WRAP = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] q;
   logic [1:0]   r;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] d;
   logic         ovf;

   int n_pass  = 0;
   int n_total = 0;

   mul3_rem_serial #(.W(W), .DIGIT(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .q         (q),
      .r         (r),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .d         (d),
      .ovf       (ovf)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present q/r until accepted; returns cycles from accept edge to out_valid.
   task automatic run_txn(input logic [W-1:0] qv, input logic [1:0] rv,
                          output int lat);
      int guard;
      guard = 0;
      while (!in_ready && guard < 200) begin
         tick();
         guard++;
      end
      n_total++;
      if (!in_ready) $display("FAIL accept_wait in_ready=%0b want 1", in_ready);
      else n_pass++;
      in_valid = 1'b1;
      q        = qv;
      r        = rv;
      tick();
      in_valid = 1'b0;
      q        = '1;
      r        = 2'd3;
      lat = 0;
      while (!out_valid && lat < 100) begin
         tick();
         lat++;
      end
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      in_valid  = 1'b0;
      q         = '0;
      r         = '0;
      out_ready = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      tick();
      n_total++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || d !== '0 || ovf !== 1'b0)
         $display("FAIL reset ir=%0b ov=%0b d=%h ovf=%0b want 1 0 0 0",
                  in_ready, out_valid, d, ovf);
      else n_pass++;
   endtask

   task automatic test_basic();
      int lat;
      run_txn(64'h0123456789ABCDEF, 2'd2, lat);
      n_total++;
      if (lat !== 16) $display("FAIL basic_latency got %0d want 16", lat);
      else n_pass++;
      n_total++;
      if (d !== 64'h0369D0369D0369CF)
         $display("FAIL basic_d got %h want 0369d0369d0369cf", d);
      else n_pass++;
      n_total++;
      if (ovf !== 1'b0) $display("FAIL basic_ovf got %0b want 0", ovf);
      else n_pass++;
      tick();
      n_total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1)
         $display("FAIL done_one_cycle ov=%0b ir=%0b want 0 1", out_valid, in_ready);
      else n_pass++;
   endtask

   task automatic test_all_ones();
      int lat;
      run_txn(64'h5555555555555555, 2'd0, lat);
      n_total++;
      if (d !== 64'hFFFFFFFFFFFFFFFF || ovf !== 1'b0)
         $display("FAIL all_ones d=%h ovf=%0b want ffffffffffffffff 0", d, ovf);
      else n_pass++;
      tick();
   endtask

   task automatic test_wrap();
      int lat;
      run_txn(64'h5555555555555555, 2'd1, lat);
      n_total++;
      if (d !== 64'h0) $display("FAIL wrap_d got %h want 0", d);
      else n_pass++;
      n_total++;
      if (ovf !== EXP_OVF_WRAP)
         $display("FAIL wrap_ovf got %0b want %0b", ovf, EXP_OVF_WRAP);
      else n_pass++;
      tick();
      n_total++;
      if (ovf !== 1'b0) $display("FAIL ovf_clear got %0b want 0", ovf);
      else n_pass++;
   endtask

   task automatic test_backpressure();
      int lat;
      logic ok;
      out_ready = 1'b0;
      run_txn(64'h0123456789ABCDEF, 2'd2, lat);
      n_total++;
      if (out_valid !== 1'b1) $display("FAIL bp_valid got %0b want 1", out_valid);
      else n_pass++;
      ok       = 1'b1;
      in_valid = 1'b1;
      q        = 64'h7;
      r        = 2'd1;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (d !== 64'h0369D0369D0369CF || out_valid !== 1'b1 || in_ready !== 1'b0)
            ok = 1'b0;
      end
      in_valid = 1'b0;
      n_total++;
      if (!ok) $display("FAIL bp_hold d=%h ov=%0b ir=%0b want 0369d0369d0369cf 1 0",
                        d, out_valid, in_ready);
      else n_pass++;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      n_total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1)
         $display("FAIL bp_release ov=%0b ir=%0b want 0 1", out_valid, in_ready);
      else n_pass++;
      out_ready = 1'b1;
      run_txn(64'h1, 2'd1, lat);
      n_total++;
      if (d !== 64'd4 || lat !== 16)
         $display("FAIL bp_next d=%h lat=%0d want 4 16", d, lat);
      else n_pass++;
      tick();
   endtask

   task automatic test_reset_midrun();
      int lat;
      in_valid = 1'b1;
      q        = 64'h0123456789ABCDEF;
      r        = 2'd2;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 7; i++) tick();
      rst = 1'b1;
      #1;
      n_total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1)
         $display("FAIL midrun_async ov=%0b ir=%0b want 0 1", out_valid, in_ready);
      else n_pass++;
      tick();
      rst = 1'b0;
      tick();
      tick();
      n_total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1)
         $display("FAIL midrun_idle ov=%0b ir=%0b want 0 1", out_valid, in_ready);
      else n_pass++;
      run_txn(64'h2, 2'd0, lat);
      n_total++;
      if (d !== 64'd6 || ovf !== 1'b0 || lat !== 16)
         $display("FAIL midrun_fresh d=%h ovf=%0b lat=%0d want 6 0 16", d, ovf, lat);
      else n_pass++;
      tick();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_all_ones();
      test_wrap();
      test_backpressure();
      test_reset_midrun();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
